// File: rtl/sc_game_status_if.sv
// Bus between the last-register comparator / prescaler side and the game-status controller.
// The controller connects through the slave modport; the upstream driver uses master.
interface sc_game_status_if #(
    parameter int LIVES_WIDTH = 2,
    parameter int LEVEL_WIDTH = 3
);
    logic                   SC_GameSTATUS_start_InHigh;
    logic                   SC_GameSTATUS_tick_In;
    logic [1:0]             SC_GameSTATUS_win_InBUS;
    logic [2:0]             SC_GameSTATUS_state_OutBUS;
    logic [LIVES_WIDTH-1:0] SC_GameSTATUS_lives_OutBUS;
    logic [LEVEL_WIDTH-1:0] SC_GameSTATUS_level_OutBUS;
    logic                   SC_GameSTATUS_clearBoard_Out;
    logic                   SC_GameSTATUS_run_Out;

    modport master (
        output SC_GameSTATUS_start_InHigh,
        output SC_GameSTATUS_tick_In,
        output SC_GameSTATUS_win_InBUS,
        input  SC_GameSTATUS_state_OutBUS,
        input  SC_GameSTATUS_lives_OutBUS,
        input  SC_GameSTATUS_level_OutBUS,
        input  SC_GameSTATUS_clearBoard_Out,
        input  SC_GameSTATUS_run_Out
    );

    modport slave (
        input  SC_GameSTATUS_start_InHigh,
        input  SC_GameSTATUS_tick_In,
        input  SC_GameSTATUS_win_InBUS,
        output SC_GameSTATUS_state_OutBUS,
        output SC_GameSTATUS_lives_OutBUS,
        output SC_GameSTATUS_level_OutBUS,
        output SC_GameSTATUS_clearBoard_Out,
        output SC_GameSTATUS_run_Out
    );
endinterface

// File: rtl/sc_game_status.sv
// Game-flow controller: start, play, hit/level-up pauses, game over and victory.
// Drives lives, level (speed select), the board-clear pulse and the road-run enable.
module sc_game_status #(
    parameter int LIVES_INIT  = 3,
    parameter int LIVES_WIDTH = 2,
    parameter int LEVEL_MAX   = 4,
    parameter int LEVEL_WIDTH = 3,
    parameter int HOLD_TICKS  = 8,
    parameter int HOLD_WIDTH  = 4
) (
    input  logic               SC_GameSTATUS_CLOCK_50,
    input  logic               SC_GameSTATUS_RESET_InHigh,
    sc_game_status_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        PLAY     = 3'b001,
        HIT      = 3'b010,
        LEVELUP  = 3'b011,
        GAMEOVER = 3'b100,
        VICTORY  = 3'b101
    } state_t;

    localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST = LEVEL_WIDTH'(LEVEL_MAX - 1);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_LAST  = HOLD_WIDTH'(HOLD_TICKS - 1);

    state_t                 state_q, state_d;
    logic [LIVES_WIDTH-1:0] lives_q, lives_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
    logic                   clear_q, clear_d;
    logic                   run_q, run_d;
    logic                   start_prev_q;
    logic                   start_edge;

    assign start_edge = bus.SC_GameSTATUS_start_InHigh & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        hold_d  = hold_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE, GAMEOVER, VICTORY: begin
                if (start_edge) begin
                    lives_d = LIVES_LOAD;
                    level_d = '0;
                    hold_d  = '0;
                    clear_d = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // The clearBoard cycle is a guard: the board is still reloading.
                if (!clear_q) begin
                    if (bus.SC_GameSTATUS_win_InBUS == 2'b10) begin
                        lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                        hold_d  = '0;
                        state_d = HIT;
                    end else if (bus.SC_GameSTATUS_win_InBUS == 2'b00) begin
                        hold_d  = '0;
                        state_d = LEVELUP;
                    end
                end
            end
            HIT: begin
                if (bus.SC_GameSTATUS_tick_In) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        if (lives_q == '0) begin
                            state_d = GAMEOVER;
                        end else begin
                            clear_d = 1'b1;
                            state_d = PLAY;
                        end
                    end
                end
            end
            LEVELUP: begin
                if (bus.SC_GameSTATUS_tick_In) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        if (level_q == LEVEL_LAST) begin
                            state_d = VICTORY;
                        end else begin
                            level_d = level_q + 1'b1;
                            clear_d = 1'b1;
                            state_d = PLAY;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        run_d = (state_d == PLAY);
    end

    always_ff @(posedge SC_GameSTATUS_CLOCK_50) begin
        if (SC_GameSTATUS_RESET_InHigh) begin
            state_q      <= IDLE;
            lives_q      <= '0;
            level_q      <= '0;
            hold_q       <= '0;
            clear_q      <= 1'b0;
            run_q        <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            clear_q      <= clear_d;
            run_q        <= run_d;
            start_prev_q <= bus.SC_GameSTATUS_start_InHigh;
        end
    end

    assign bus.SC_GameSTATUS_state_OutBUS   = state_q;
    assign bus.SC_GameSTATUS_lives_OutBUS   = lives_q;
    assign bus.SC_GameSTATUS_level_OutBUS   = level_q;
    assign bus.SC_GameSTATUS_clearBoard_Out = clear_q;
    assign bus.SC_GameSTATUS_run_Out        = run_q;

endmodule

// File: tb/tb_sc_game_status.sv
// Scoreboard bench for sc_game_status: directed game scenarios followed by random play,
// each cycle's expected outputs come from a phase/countdown reference model.
module tb_sc_game_status;

    localparam int LIVES_INIT = 3;
    localparam int LEVEL_MAX  = 4;
    localparam int HOLD_TICKS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_game_status_if #(.LIVES_WIDTH(2), .LEVEL_WIDTH(3)) bus ();

    sc_game_status dut (
        .SC_GameSTATUS_CLOCK_50     (clk),
        .SC_GameSTATUS_RESET_InHigh (rst),
        .bus                        (bus)
    );

    typedef struct {
        int state;
        int lives;
        int level;
        int clear;
        int run;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    bit   done   = 1'b0;
    int   cyc_no = 0;

    // Reference model: game phase plus a countdown of remaining pause ticks.
    int m_phase = 0, m_lives = 0, m_level = 0, m_left = 0;
    bit m_fresh = 0, m_prev = 1;

    task automatic model_step(input bit r, input bit st, input bit tk, input logic [1:0] w);
        bit edge_now, fresh_now;
        exp_t e;
        if (r) begin
            m_phase = 0; m_lives = 0; m_level = 0; m_left = 0;
            m_fresh = 0; m_prev = 1;
        end else begin
            edge_now  = st && !m_prev;
            m_prev    = st;
            fresh_now = m_fresh;
            m_fresh   = 0;
            if (m_phase == 0 || m_phase == 4 || m_phase == 5) begin
                if (edge_now) begin
                    m_lives = LIVES_INIT; m_level = 0; m_fresh = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!fresh_now && w == 2'b10) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_left  = HOLD_TICKS; m_phase = 2;
                end else if (!fresh_now && w == 2'b00) begin
                    m_left = HOLD_TICKS; m_phase = 3;
                end
            end else if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_phase == 2) begin
                        if (m_lives == 0) m_phase = 4;
                        else begin m_fresh = 1; m_phase = 1; end
                    end else begin
                        if (m_level == LEVEL_MAX - 1) m_phase = 5;
                        else begin m_level++; m_fresh = 1; m_phase = 1; end
                    end
                end
            end
        end
        e.state = m_phase; e.lives = m_lives; e.level = m_level;
        e.clear = m_fresh; e.run = (m_phase == 1);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record what the next rising edge must produce.
    task automatic cyc(input bit r, input bit st, input bit tk, input logic [1:0] w);
        @(negedge clk);
        rst = r;
        bus.SC_GameSTATUS_start_InHigh = st;
        bus.SC_GameSTATUS_tick_In      = tk;
        bus.SC_GameSTATUS_win_InBUS    = w;
        model_step(r, st, tk, w);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 2'b11);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input int want);
        tests++;
        if (got !== 8'(want)) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_no, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 8'(bus.SC_GameSTATUS_state_OutBUS), e.state);
                check("lives", 8'(bus.SC_GameSTATUS_lives_OutBUS), e.lives);
                check("level", 8'(bus.SC_GameSTATUS_level_OutBUS), e.level);
                check("clearBoard", 8'(bus.SC_GameSTATUS_clearBoard_Out), e.clear);
                check("run", 8'(bus.SC_GameSTATUS_run_Out), e.run);
            end
        end
    end

    initial begin : stimulus
        bit st;
        int r;
        logic [1:0] w;
        bus.SC_GameSTATUS_start_InHigh = 1'b1;
        bus.SC_GameSTATUS_tick_In      = 1'b0;
        bus.SC_GameSTATUS_win_InBUS    = 2'b11;

        // Reset with start held, then release it still held: no game may start.
        repeat (3) cyc(1, 1, 0, 2'b11);
        repeat (4) cyc(0, 1, 1, 2'b11);
        cyc(0, 0, 0, 2'b11);
        // Start edge; level-won code during the clearBoard guard cycle is ignored.
        cyc(0, 1, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        repeat (2) cyc(0, 1, 0, 2'b11);

        // Three collisions, tick on each entry cycle, leading to game over.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 2'b10);
            cyc(0, 0, 1, 2'b00);
            hold(HOLD_TICKS - 1);
            cyc(0, 0, 0, 2'b11);
            cyc(0, 0, 0, 2'b11);
        end
        // Restart from game over, then clear every level to reach victory.
        cyc(0, 1, 0, 2'b11);
        cyc(0, 1, 0, 2'b11);
        for (int k = 0; k < LEVEL_MAX; k++) begin
            cyc(0, 1, 0, 2'b00);
            hold(HOLD_TICKS);
            cyc(0, 1, 0, 2'b11);
        end
        // Restart from victory, enter LEVELUP and reset at hold = 5.
        cyc(0, 0, 0, 2'b11);
        cyc(0, 1, 0, 2'b11);
        cyc(0, 1, 0, 2'b11);
        cyc(0, 1, 0, 2'b00);
        hold(5);
        cyc(1, 1, 0, 2'b11);
        cyc(0, 0, 0, 2'b11);
        // Reserved and idle codes keep PLAY.
        cyc(0, 1, 0, 2'b11);
        for (int k = 0; k < 6; k++) cyc(0, 1, k[0], (k % 2 == 0) ? 2'b01 : 2'b11);

        // Random play.
        st = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9) == 0) st = ~st;
            r = $urandom_range(0, 19);
            w = (r < 2) ? 2'b10 : (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b11;
            cyc(($urandom_range(0, 599) == 0), st, ($urandom_range(0, 2) == 0), w);
        end

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sc_game_status.md
Name: sc_game_status

Overview:
- Sequential game-status controller that sits directly downstream of the last-register comparator.
- Consumes the comparator's 2-bit per-cycle status code:
  - 00 = frog completed the top row (level won)
  - 10 = collision
  - 11 = no event
  - 01 = reserved, treated as no event
- Owns the game flow: start, play, hit pause, level-up pause, game over and victory.
- Drives the board-clear pulse, the road-run enable, the remaining lives and the current level (used as the speed select).

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..2^LIVES_WIDTH-1).
- LIVES_WIDTH, 2, width of the lives counter.
- LEVEL_MAX, 4, number of levels; clearing level LEVEL_MAX-1 wins the game.
- LEVEL_WIDTH, 3, width of the level counter (must hold LEVEL_MAX-1).
- HOLD_TICKS, 8, game ticks spent in the HIT / LEVELUP pause (>=1).
- HOLD_WIDTH, 4, width of the hold counter (must hold HOLD_TICKS).

Ports:
- SC_GameSTATUS_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_GameSTATUS_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_GameSTATUS_start_InHigh  in  1  debounced start button level; internally rising-edge detected.
- SC_GameSTATUS_tick_In  in  1  one-cycle game-tick pulse from the prescaler.
- SC_GameSTATUS_win_InBUS  in  2  status code from the last-register comparator.
- SC_GameSTATUS_state_OutBUS  out  3  current state encoding.
- SC_GameSTATUS_lives_OutBUS  out  LIVES_WIDTH  remaining lives.
- SC_GameSTATUS_level_OutBUS  out  LEVEL_WIDTH  current level, 0-based; also the speed select.
- SC_GameSTATUS_clearBoard_Out  out  1  one-cycle pulse telling the board registers to reload the initial map.
- SC_GameSTATUS_run_Out  out  1  high only in PLAY; enables road/frog shifting.

Behaviour:
- Reset: clock and reset are as decided — one clock; reset is synchronous and active-high.
  - State = IDLE, lives = 0, level = 0, hold = 0, clearBoard = 0, run = 0.
  - Start-edge register resets to 1, so a button held through reset does not start a game.
  - Reset asserted mid-game overrides everything on the next edge.
- All outputs are registered. run_Out is 1 exactly when state = PLAY.
- Start edge: start_InHigh = 1 and the previous sample = 0. Edges in PLAY, HIT and LEVELUP are ignored.
- IDLE (000): on a start edge, load lives = LIVES_INIT and level = 0, pulse clearBoard, go to PLAY.
- PLAY (001): the win code is sampled every cycle except the cycle where clearBoard = 1 (guard cycle; the board is still reloading).
  - Code 10: lives <= lives-1, saturating at 0; hold <= 0; go to HIT.
  - Code 00: hold <= 0; go to LEVELUP.
  - Codes 11 and 01: stay in PLAY.
- HIT (010): hold increments on each tick. On the tick that makes hold = HOLD_TICKS:
  - If lives = 0, go to GAMEOVER.
  - Otherwise pulse clearBoard and go to PLAY.
- LEVELUP (011): same hold rule. On completion:
  - If level = LEVEL_MAX-1, go to VICTORY; level is unchanged.
  - Otherwise level <= level+1, pulse clearBoard, go to PLAY.
- GAMEOVER (100) / VICTORY (101): lives and level are frozen for display. A start edge behaves as in IDLE (reload, clear pulse, PLAY).
- Hold counting: a tick in the same cycle as entry into HIT/LEVELUP is not counted; hold is cleared on entry. The win code is ignored in all states other than PLAY.
- clearBoard timing: high for exactly one cycle, in the first cycle of PLAY, registered together with the state change.
- Codes 110/111: unreachable. If reached, the next state is IDLE and run = 0.

Test Plan:
- Reset held with start = 1, then reset released -> state = 000, lives = 0, level = 0; no PLAY until start drops and rises again.
- Start edge from IDLE -> next cycle: state = 001, lives = 3, level = 0, clearBoard = 1 for one cycle, run = 1; code 00 during the clearBoard cycle ignored.
- In PLAY, force code 10 -> HIT, lives = 2, run = 0; after 8 ticks (tick on entry cycle not counted) -> PLAY with a clearBoard pulse.
- Three collisions -> after the third hold, state = 100, lives = 0; a start edge restarts with lives = 3, level = 0.
- Code 00 four times with holds -> level goes 1, 2, 3, then state = 101 with level = 3; no clearBoard on the final transition.
- Reset asserted mid-LEVELUP at hold = 5 -> next edge: state = 000, all counters 0, run = 0; codes 01/11 in PLAY cause no transition.
